ex_unit_mc: RTL
===============

# ex_unit_mc

Parametrised, multi-cycle successor to the single-cycle execute stage. It sits between the ID/EX buffer and the EX/MEM buffer. It owns the architectural flag register (NF|CF|ZF) and the stack pointer, and adds an iterative shift-add multiplier. A valid/ready handshake on both sides lets a multi-cycle operation stall the front end and lets the memory stage apply backpressure.

## Interface
Parameters:
- WIDTH, 16, operand width (≥4, power of two)
- SP_WIDTH, 32, stack pointer / address width
- SP_INIT, 32'h000F_FFFF, stack pointer reset value

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ID/EX presents an operation
- in_ready  out  1  unit accepts the operation this cycle
- op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHL, 5 SHR, 6 MOV (pass a), 7 NOT, 8 MUL, 9–15 behave as MOV
- a, b  in  WIDTH  operands, already forwarded
- fd  in  2  flag decision: 00 clear CF, 01 set CF, 10 keep, 11 update from ALU
- sp_en, sp_pop  in  1  stack access; sp_pop=1 pop, 0 push
- flags_load  in  1  restore flags from memory
- flags_in  in  3  restored {NF,CF,ZF}
- out_valid  out  1  result register holds an un-consumed result
- out_ready  in  1  EX/MEM consumes the result
- result  out  2*WIDTH  registered result; single-cycle ops are zero-extended
- addr  out  SP_WIDTH  registered stack address for the result
- flags  out  3  flag register {NF,CF,ZF}
- sp  out  SP_WIDTH  stack pointer register
- busy  out  1  high while in state MUL

## Operation
- States:
  - IDLE → MUL on accepting op=8.
  - MUL → IDLE when the iteration counter reaches WIDTH-1.
  - Every other accepted op stays in IDLE.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Accept = in_valid && in_ready.
- Single-cycle ops:
  - On the accept edge, result, addr and out_valid=1 load together.
  - Flags update on the same edge per fd.
- fd=11 flag rules:
  - ZF = (result==0); NF = result[WIDTH-1].
  - CF: ADD takes the carry-out. SUB takes the borrow (a<b). SHL takes bit WIDTH of ({1'b0,a}<<b). All other ops keep CF.
  - Shift amount is the full b; b≥WIDTH+1 gives result 0, and SHL CF 0.
- MUL:
  - The accept edge latches a and b and clears the accumulator.
  - Each MUL cycle tests multiplier bit i, conditionally adds the shifted multiplicand, and increments i.
  - On the final cycle the product loads into result and out_valid goes 1.
  - Flags (fd=11) update on that edge: ZF = (product==0), NF = product[2*WIDTH-1], CF = |product[2*WIDTH-1:WIDTH].
  - fd=00/01/10 apply at completion.
- Stack: applied on the accept edge, including for MUL.
  - Push: addr=sp, sp←sp-1.
  - Pop: sp←sp+1, addr=sp+1.
  - sp_en=0: addr = zero-extended b, sp unchanged.
- Arithmetic is modulo 2^SP_WIDTH; sp wraps 0 → all-ones on push and all-ones → 0 on pop.
- flags_load is honoured in any state and any cycle, accept or not. It overrides any same-edge fd update.
- Output: out_valid clears on out_ready when no new result loads the same edge. Simultaneous consume and load keeps out_valid=1 with the new data.

## Timing
- Reset values:
  - state IDLE, counter 0
  - out_valid 0, result 0, addr 0
  - flags 000, sp SP_INIT, busy 0
  - in_ready 1 the cycle after reset deasserts
- Single-cycle op latency: 1 cycle (accept edge → out_valid high). Back-to-back throughput is 1 per cycle with out_ready=1.
- MUL latency: WIDTH+1 edges from accept to out_valid. in_ready is low for WIDTH cycles.
- result, addr and flags hold stable while out_valid=1 and out_ready=0.
- rst during MUL aborts it: no result is produced and the partial product is discarded.

## Test plan
- ADD a=0xFFFF, b=0x0001, fd=11 → next cycle result=0x0000_0000, flags=3'b011, out_valid=1.
- MUL a=0x0100, b=0x0100, fd=11 → busy high and in_ready low for 16 cycles; result=0x0001_0000 on the 17th edge; flags=3'b010.
- out_ready=0 with a result pending and in_valid=1 → in_ready=0, result unchanged for 5 cycles. Raise out_ready → new op accepted that edge, next result appears the following cycle.
- From SP_INIT: push, push, pop → addr 0xFFFFF, 0xFFFFE, 0xFFFFE; sp ends at 0x000FFFFE.
- flags_load=1, flags_in=3'b101 on the same edge as an ADD with fd=11 → flags=3'b101.
- rst at MUL cycle 5 → next cycle out_valid=0, busy=0, in_ready=1, sp=SP_INIT, flags=000; no result ever appears.

Source files
------------

// File: rtl/ex_unit_mc.sv
// Multi-cycle execute stage: single-cycle ALU, iterative shift-add multiplier,
// flag register and stack pointer, with valid/ready handshakes on both sides.
module ex_unit_mc #(
  parameter int                  WIDTH    = 16,
  parameter int                  SP_WIDTH = 32,
  parameter logic [SP_WIDTH-1:0] SP_INIT  = 32'h000F_FFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            op,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic [1:0]            fd,
  input  logic                  sp_en,
  input  logic                  sp_pop,
  input  logic                  flags_load,
  input  logic [2:0]            flags_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*WIDTH-1:0]    result,
  output logic [SP_WIDTH-1:0]   addr,
  output logic [2:0]            flags,
  output logic [SP_WIDTH-1:0]   sp,
  output logic                  busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t               r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_mcand, r_acc, r_result;
  logic [WIDTH-1:0]     r_mplier;
  logic [1:0]           r_mfd;
  logic [SP_WIDTH-1:0]  r_addr, r_sp;
  logic [2:0]           r_flags;
  logic                 r_out_valid;

  logic                 w_accept, w_is_mul, w_mul_last, w_in_ready;
  logic [WIDTH:0]       w_sum, w_shl;
  logic [WIDTH-1:0]     w_alu_res;
  logic                 w_alu_cf, w_cf_upd;
  logic [2*WIDTH-1:0]   w_prod;
  logic [2:0]           w_flags_alu, w_flags_mul;
  logic [SP_WIDTH-1:0]  w_sp_nxt, w_addr_nxt;

  // Flags are {NF,CF,ZF}; fd=11 only touches CF for ops that produce a carry.
  function automatic logic [2:0] f_next_flags(input logic [1:0] fdv, input logic [2:0] cur,
                                              input logic nf, input logic cf,
                                              input logic zf, input logic cf_upd);
    logic [2:0] nxt;
    nxt = cur;
    case (fdv)
      2'b00:   nxt[1] = 1'b0;
      2'b01:   nxt[1] = 1'b1;
      2'b10:   nxt = cur;
      2'b11: begin
        nxt[2] = nf;
        nxt[0] = zf;
        if (cf_upd) nxt[1] = cf;
        else        nxt[1] = cur[1];
      end
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  assign w_in_ready = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && w_in_ready;
  assign w_is_mul   = (op == 4'd8);
  assign w_mul_last = (r_state == S_MUL) && (r_cnt == CW'(WIDTH - 1));
  assign w_sum      = {1'b0, a} + {1'b0, b};
  assign w_shl      = {1'b0, a} << b;
  assign w_prod     = r_acc + (r_mplier[0] ? r_mcand : {(2*WIDTH){1'b0}});

  // Next-state logic for the IDLE/MUL controller.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_mul) w_state_nxt = S_MUL;
        else                      w_state_nxt = S_IDLE;
      end
      S_MUL: begin
        if (w_mul_last) w_state_nxt = S_IDLE;
        else            w_state_nxt = S_MUL;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Single-cycle ALU; reserved opcodes pass a through like MOV.
  always_comb begin
    w_alu_res = a;
    w_alu_cf  = 1'b0;
    w_cf_upd  = 1'b0;
    case (op)
      4'd0: begin w_alu_res = w_sum[WIDTH-1:0]; w_alu_cf = w_sum[WIDTH]; w_cf_upd = 1'b1; end
      4'd1: begin w_alu_res = a - b;            w_alu_cf = (a < b);      w_cf_upd = 1'b1; end
      4'd2: w_alu_res = a & b;
      4'd3: w_alu_res = a | b;
      4'd4: begin w_alu_res = w_shl[WIDTH-1:0]; w_alu_cf = w_shl[WIDTH]; w_cf_upd = 1'b1; end
      4'd5: w_alu_res = a >> b;
      4'd7: w_alu_res = ~a;
      default: w_alu_res = a;
    endcase
  end

  // Stack pointer update and the address that travels with the result.
  always_comb begin
    w_sp_nxt   = r_sp;
    w_addr_nxt = SP_WIDTH'(b);
    if (!sp_en) begin
      w_sp_nxt   = r_sp;
      w_addr_nxt = SP_WIDTH'(b);
    end else if (sp_pop) begin
      w_sp_nxt   = r_sp + SP_WIDTH'(1);
      w_addr_nxt = r_sp + SP_WIDTH'(1);
    end else begin
      w_sp_nxt   = r_sp - SP_WIDTH'(1);
      w_addr_nxt = r_sp;
    end
  end

  assign w_flags_alu = f_next_flags(fd, r_flags, w_alu_res[WIDTH-1], w_alu_cf,
                                    (w_alu_res == {WIDTH{1'b0}}), w_cf_upd);
  assign w_flags_mul = f_next_flags(r_mfd, r_flags, w_prod[2*WIDTH-1], |w_prod[2*WIDTH-1:WIDTH],
                                    (w_prod == {(2*WIDTH){1'b0}}), 1'b1);

  // State, multiplier datapath, result/handshake, flags and stack registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mcand     <= '0;
      r_acc       <= '0;
      r_mplier    <= '0;
      r_mfd       <= 2'b00;
      r_result    <= '0;
      r_addr      <= '0;
      r_flags     <= 3'b000;
      r_sp        <= SP_INIT;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_sp   <= w_sp_nxt;
        r_addr <= w_addr_nxt;
      end
      if (w_accept && w_is_mul) begin
        r_mcand  <= {{WIDTH{1'b0}}, a};
        r_mplier <= b;
        r_acc    <= '0;
        r_cnt    <= '0;
        r_mfd    <= fd;
      end else if (r_state == S_MUL) begin
        r_acc    <= w_prod;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CW'(1);
      end
      if (w_accept && !w_is_mul) begin
        r_result    <= {{WIDTH{1'b0}}, w_alu_res};
        r_out_valid <= 1'b1;
      end else if (w_mul_last) begin
        r_result    <= w_prod;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      // A memory restore wins over any flag update on the same edge.
      if (flags_load)                r_flags <= flags_in;
      else if (w_accept && !w_is_mul) r_flags <= w_flags_alu;
      else if (w_mul_last)           r_flags <= w_flags_mul;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign addr      = r_addr;
  assign flags     = r_flags;
  assign sp        = r_sp;
  assign busy      = (r_state == S_MUL);

endmodule
